pipeline_interlock: RTL and testbench
=====================================

// Module: pipeline_interlock
// PURPOSE
//  Hazard/interlock controller for the 5-stage integer pipeline. Drives the
//  select lines of the ID-stage bypass muxes, and stalls IF/ID (inserting an
//  EX bubble) on load-use and multiply/divide hazards. Freezes the whole
//  pipeline while a data-memory access is outstanding. Sits beside the
//  decode stage and feeds the stall/flush inputs of every pipeline register.
// PARAMETERS
//  MULDIV_LATENCY  32  cycles from an accepted mul/div start to HI/LO valid (>=1)
//  CNT_W           6   muldiv counter width; must hold MULDIV_LATENCY
// PORTS
//  clk             in   1  pipeline clock
//  rst_n           in   1  asynchronous reset, active low
//  id_rs_addr      in   5  rs source register of the ID instruction
//  id_rt_addr      in   5  rt source register of the ID instruction
//  id_rs_used      in   1  ID instruction reads rs
//  id_rt_used      in   1  ID instruction reads rt
//  id_muldiv_start in   1  ID instruction is mult/multu/div/divu
//  id_hilo_read    in   1  ID instruction is mfhi/mflo
//  ex_reg_en       in   1  EX instruction writes a GPR
//  ex_reg_addr     in   5  EX destination register
//  ex_is_load      in   1  EX instruction is a load
//  mem_reg_en      in   1  MEM instruction writes a GPR
//  mem_reg_addr    in   5  MEM destination register
//  mem_req         in   1  MEM stage issues a data-memory access this cycle
//  mem_ready       in   1  data memory completes the access this cycle
//  bypass_sel_rs   out  2  rs mux: 00 regfile, 01 EX, 10 MEM, 11 zero
//  bypass_sel_rt   out  2  rt mux, same encoding
//  stall_if        out  1  hold PC / IF-ID register
//  stall_id        out  1  hold ID-EX inputs (ID instruction is not issued)
//  flush_ex        out  1  load a bubble into ID-EX
//  stall_ex        out  1  hold EX-MEM register
//  stall_mem       out  1  hold MEM-WB register
//  muldiv_busy     out  1  mul/div unit is computing
// BEHAVIOUR
//  - bypass_sel_* (combinational), per operand: addr==0 -> 11; else
//    ex_reg_en & ex_reg_addr match -> 01; else mem_reg_en & mem_reg_addr
//    match -> 10; else 00. EX has priority over MEM.
//  - FSM states RUN and MEM_WAIT; reset state RUN.
//    RUN -> MEM_WAIT when mem_req & !mem_ready.
//    MEM_WAIT -> RUN when mem_ready. mem_req is ignored in MEM_WAIT.
//  - freeze = (RUN & mem_req & !mem_ready) | (MEM_WAIT & !mem_ready).
//    freeze drives all four stall_* = 1 and forces flush_ex = 0.
//  - load_use = ex_is_load & ex_reg_en & ex_reg_addr!=0 & ex_reg_addr matches
//    a used operand (rs if id_rs_used, rt if id_rt_used).
//  - md_haz = muldiv_busy & (id_hilo_read | id_muldiv_start).
//  - If !freeze & (load_use | md_haz): stall_if=stall_id=flush_ex=1 and
//    stall_ex=stall_mem=0. The load-use stall lasts exactly 1 cycle, because the
//    next cycle sees the load in MEM with bypass sel 10.
//  - Muldiv counter: loads MULDIV_LATENCY when id_muldiv_start & !stall_id.
//    Otherwise it decrements when nonzero, including during freeze.
//    muldiv_busy = (cnt != 0), registered. When cnt goes 1->0, busy drops the
//    next cycle and mfhi/mflo issues in that cycle.
//  - Simultaneous hazards: freeze > md_haz > load_use. Outputs are identical
//    for md_haz and load_use.
//  - Reset (any cycle, including mid-muldiv or in MEM_WAIT): FSM -> RUN,
//    cnt -> 0, muldiv_busy = 0. While rst_n is low, all stall_*/flush_ex = 0.
//    bypass_sel_* keep following their inputs.
// CONFIGURATION
//  - Macro INTERLOCK_STATS_EN:
//    - Defined: adds output stall_cycles [31:0], which counts cycles with
//      stall_id=1. The count wraps at 2^32 and is cleared by reset.
//      Also adds output freeze_cycles [31:0], which counts freeze cycles
//      the same way.
//    - Undefined: these ports and counters are absent; all other behaviour
//      is identical.
// TESTING
//  - rs=5 used, EX writes r5 (non-load), MEM writes r5 -> sel_rs=01, no stall.
//  - rt=0 used, EX writes r0 -> sel_rt=11, no stall.
//  - ex_is_load, ex_reg_addr=7, id_rs_addr=7 used -> 1 cycle of
//    stall_if/id=1, flush_ex=1; next cycle load in MEM -> sel_rs=10, no stall.
//  - mult accepted with MULDIV_LATENCY=4, then mfhi -> busy for 4 cycles,
//    stall+bubble for those 4 cycles, mfhi issues on cycle 5.
//  - mem_req=1, mem_ready low for 3 cycles -> all stall_*=1 for 3 cycles and
//    state MEM_WAIT; a simultaneous load_use gives flush_ex=0 until the
//    freeze ends.
//  - rst_n low while cnt=10 and in MEM_WAIT -> busy=0, state RUN, and
//    stalls=0 immediately (async).

Source files
------------

// File: rtl/pipeline_interlock.sv
// Hazard/interlock controller: ID bypass selects, load-use and mul/div stalls, memory-wait freeze.
// Optional INTERLOCK_STATS_EN adds stall_cycles/freeze_cycles counters.
module pipeline_interlock #(
  parameter int MULDIV_LATENCY = 32,
  parameter int CNT_W          = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       id_muldiv_start,
  input  logic       id_hilo_read,
  input  logic       ex_reg_en,
  input  logic [4:0] ex_reg_addr,
  input  logic       ex_is_load,
  input  logic       mem_reg_en,
  input  logic [4:0] mem_reg_addr,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic [1:0] bypass_sel_rs,
  output logic [1:0] bypass_sel_rt,
  output logic       stall_if,
  output logic       stall_id,
  output logic       flush_ex,
  output logic       stall_ex,
  output logic       stall_mem,
  output logic       muldiv_busy
`ifdef INTERLOCK_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] freeze_cycles
`endif
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_freeze;
  logic             w_load_use;
  logic             w_md_haz;
  logic             w_hazard;

  function automatic logic [1:0] f_sel(input logic [4:0] a, input logic ex_en,
                                       input logic [4:0] ex_a, input logic mem_en,
                                       input logic [4:0] mem_a);
    if (a == 5'd0)                 return 2'b11;
    else if (ex_en && ex_a == a)   return 2'b01;
    else if (mem_en && mem_a == a) return 2'b10;
    else                           return 2'b00;
  endfunction

  assign bypass_sel_rs = f_sel(id_rs_addr, ex_reg_en, ex_reg_addr, mem_reg_en, mem_reg_addr);
  assign bypass_sel_rt = f_sel(id_rt_addr, ex_reg_en, ex_reg_addr, mem_reg_en, mem_reg_addr);

  assign muldiv_busy = (r_cnt != '0);

  // rst_n gates every control output so reset quiets the pipeline without waiting for a clock
  assign w_freeze = rst_n & (((r_state == ST_RUN) & mem_req & ~mem_ready) |
                             ((r_state == ST_MEM_WAIT) & ~mem_ready));

  assign w_load_use = ex_is_load & ex_reg_en & (ex_reg_addr != 5'd0) &
                      ((id_rs_used & (id_rs_addr == ex_reg_addr)) |
                       (id_rt_used & (id_rt_addr == ex_reg_addr)));

  assign w_md_haz = muldiv_busy & (id_hilo_read | id_muldiv_start);
  assign w_hazard = rst_n & ~w_freeze & (w_load_use | w_md_haz);

  assign stall_if  = w_freeze | w_hazard;
  assign stall_id  = w_freeze | w_hazard;
  assign flush_ex  = w_hazard;
  assign stall_ex  = w_freeze;
  assign stall_mem = w_freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:      if (mem_req && !mem_ready) r_state <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (mem_ready)             r_state <= ST_RUN;
        default:                                r_state <= ST_RUN;
      endcase
    end
  end

  // counter keeps running through a freeze; a stalled start is not accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_cnt <= '0;
    else if (id_muldiv_start && !stall_id) r_cnt <= CNT_W'(MULDIV_LATENCY);
    else if (r_cnt != '0)                 r_cnt <= r_cnt - CNT_W'(1);
  end

`ifdef INTERLOCK_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_freeze_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles  <= '0;
      r_freeze_cycles <= '0;
    end else begin
      r_stall_cycles  <= r_stall_cycles + 32'(stall_id);
      r_freeze_cycles <= r_freeze_cycles + 32'(w_freeze);
    end
  end

  assign stall_cycles  = r_stall_cycles;
  assign freeze_cycles = r_freeze_cycles;
`endif

endmodule

// File: tb/tb_pipeline_interlock.sv
// Bench for pipeline_interlock: vector table, directed corner sequences, randomized run vs model.
module tb_pipeline_interlock;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs_addr, id_rt_addr, ex_reg_addr, mem_reg_addr;
  logic       id_rs_used, id_rt_used, id_muldiv_start, id_hilo_read;
  logic       ex_reg_en, ex_is_load, mem_reg_en, mem_req, mem_ready;
  logic [1:0] bypass_sel_rs, bypass_sel_rt;
  logic       stall_if, stall_id, flush_ex, stall_ex, stall_mem, muldiv_busy;
`ifdef INTERLOCK_STATS_EN
  logic [31:0] stall_cycles, freeze_cycles;
`endif

  int checks = 0;
  int errors = 0;

  pipeline_interlock #(.MULDIV_LATENCY(LAT), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_muldiv_start(id_muldiv_start), .id_hilo_read(id_hilo_read),
    .ex_reg_en(ex_reg_en), .ex_reg_addr(ex_reg_addr), .ex_is_load(ex_is_load),
    .mem_reg_en(mem_reg_en), .mem_reg_addr(mem_reg_addr),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .bypass_sel_rs(bypass_sel_rs), .bypass_sel_rt(bypass_sel_rt),
    .stall_if(stall_if), .stall_id(stall_id), .flush_ex(flush_ex),
    .stall_ex(stall_ex), .stall_mem(stall_mem), .muldiv_busy(muldiv_busy)
`ifdef INTERLOCK_STATS_EN
    , .stall_cycles(stall_cycles), .freeze_cycles(freeze_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic       rsu, rtu;
    logic       exen;
    logic [4:0] exa;
    logic       exld;
    logic       memen;
    logic [4:0] mema;
    logic [1:0] ers, ert;
    logic       est;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_rs_addr = 0; id_rt_addr = 0; id_rs_used = 0; id_rt_used = 0;
    id_muldiv_start = 0; id_hilo_read = 0;
    ex_reg_en = 0; ex_reg_addr = 0; ex_is_load = 0;
    mem_reg_en = 0; mem_reg_addr = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_ctl(input string name, input logic sif, input logic sid,
                         input logic fl, input logic sex, input logic smem);
    chk({name, ".stall_if"},  int'(stall_if),  int'(sif));
    chk({name, ".stall_id"},  int'(stall_id),  int'(sid));
    chk({name, ".flush_ex"},  int'(flush_ex),  int'(fl));
    chk({name, ".stall_ex"},  int'(stall_ex),  int'(sex));
    chk({name, ".stall_mem"}, int'(stall_mem), int'(smem));
  endtask

  // reference model state
  bit m_wait;
  int m_cnt;

  function automatic logic [1:0] ref_sel(input logic [4:0] a);
    if (a == 0) return 2'b11;
    if (ex_reg_en && ex_reg_addr == a) return 2'b01;
    if (mem_reg_en && mem_reg_addr == a) return 2'b10;
    return 2'b00;
  endfunction

  initial begin
    bit freeze, lu, mdh, sid;
    idle();
    rst_n = 1'b0;
    #1;
    chk("reset.busy", int'(muldiv_busy), 0);
    chk_ctl("reset", 0, 0, 0, 0, 0);
    #20 rst_n = 1'b1;
    step();

    // ---------------- bypass / load-use vector table ----------------
    //          rs  rt rsu rtu exen exa exld memen mema  ers    ert   est
    vecs[0] = '{5, 0, 1, 0, 1, 5, 0, 1, 5, 2'b01, 2'b11, 0};
    vecs[1] = '{3, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b11, 0};
    vecs[2] = '{9, 4, 1, 1, 1, 2, 0, 1, 4, 2'b00, 2'b10, 0};
    vecs[3] = '{7, 1, 1, 0, 1, 7, 1, 0, 0, 2'b01, 2'b00, 1};
    vecs[4] = '{7, 8, 0, 1, 1, 7, 1, 0, 0, 2'b01, 2'b00, 0};
    vecs[5] = '{6, 6, 0, 1, 1, 6, 1, 1, 6, 2'b01, 2'b01, 1};
    vecs[6] = '{0, 0, 1, 1, 1, 0, 1, 1, 0, 2'b11, 2'b11, 0};
    vecs[7] = '{12, 12, 1, 1, 0, 12, 1, 1, 12, 2'b10, 2'b10, 0};
    foreach (vecs[i]) begin
      idle();
      id_rs_addr = vecs[i].rs; id_rt_addr = vecs[i].rt;
      id_rs_used = vecs[i].rsu; id_rt_used = vecs[i].rtu;
      ex_reg_en = vecs[i].exen; ex_reg_addr = vecs[i].exa; ex_is_load = vecs[i].exld;
      mem_reg_en = vecs[i].memen; mem_reg_addr = vecs[i].mema;
      @(negedge clk);
      chk($sformatf("vec%0d.sel_rs", i), int'(bypass_sel_rs), int'(vecs[i].ers));
      chk($sformatf("vec%0d.sel_rt", i), int'(bypass_sel_rt), int'(vecs[i].ert));
      chk_ctl($sformatf("vec%0d", i), vecs[i].est, vecs[i].est, vecs[i].est, 0, 0);
      step();
    end

    // ---------------- load-use then MEM bypass ----------------
    idle();
    id_rs_addr = 7; id_rs_used = 1; ex_reg_en = 1; ex_reg_addr = 7; ex_is_load = 1;
    @(negedge clk);
    chk_ctl("lu.c0", 1, 1, 1, 0, 0);
    step();
    ex_reg_en = 0; ex_is_load = 0; ex_reg_addr = 0; mem_reg_en = 1; mem_reg_addr = 7;
    @(negedge clk);
    chk("lu.c1.sel_rs", int'(bypass_sel_rs), 2);
    chk_ctl("lu.c1", 0, 0, 0, 0, 0);
    step();

    // ---------------- mult then mfhi ----------------
    idle();
    id_muldiv_start = 1;
    @(negedge clk);
    chk("md.start.stall_id", int'(stall_id), 0);
    step();
    id_muldiv_start = 0; id_hilo_read = 1;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      chk($sformatf("md.c%0d.busy", c), int'(muldiv_busy), 1);
      chk_ctl($sformatf("md.c%0d", c), 1, 1, 1, 0, 0);
      step();
    end
    @(negedge clk);
    chk("md.issue.busy", int'(muldiv_busy), 0);
    chk_ctl("md.issue", 0, 0, 0, 0, 0);
    step();

    // ---------------- memory wait with concurrent load-use ----------------
    idle();
    id_rs_addr = 7; id_rs_used = 1; ex_reg_en = 1; ex_reg_addr = 7; ex_is_load = 1;
    mem_req = 1; mem_ready = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_ctl($sformatf("mw.c%0d", c), 1, 1, 0, 1, 1);
      step();
      mem_req = 0; // ignored while waiting
    end
    mem_ready = 1;
    @(negedge clk);
    chk_ctl("mw.done", 1, 1, 1, 0, 0);
    step();

    // ---------------- async reset mid-muldiv and in MEM_WAIT ----------------
    idle();
    id_muldiv_start = 1;
    step();
    id_muldiv_start = 0; mem_req = 1; mem_ready = 0;
    step();
    id_hilo_read = 1; mem_req = 0;
    @(negedge clk);
    chk("rst.pre.busy", int'(muldiv_busy), 1);
    chk_ctl("rst.pre", 1, 1, 0, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.busy", int'(muldiv_busy), 0);
    chk_ctl("rst.low", 0, 0, 0, 0, 0);
    id_rs_addr = 3; ex_reg_en = 1; ex_reg_addr = 3;
    #1;
    chk("rst.sel_rs", int'(bypass_sel_rs), 1);
    step();
    id_hilo_read = 0; ex_reg_en = 0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_ctl("rst.after", 0, 0, 0, 0, 0);
    step();

    // ---------------- randomized run against model ----------------
    m_wait = 0; m_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      id_rs_addr = 5'($urandom_range(0, 3)); id_rt_addr = 5'($urandom_range(0, 3));
      id_rs_used = 1'($urandom); id_rt_used = 1'($urandom);
      id_muldiv_start = ($urandom_range(0, 9) == 0);
      id_hilo_read = ($urandom_range(0, 5) == 0);
      ex_reg_en = 1'($urandom); ex_reg_addr = 5'($urandom_range(0, 3));
      ex_is_load = 1'($urandom);
      mem_reg_en = 1'($urandom); mem_reg_addr = 5'($urandom_range(0, 3));
      mem_req = ($urandom_range(0, 3) == 0); mem_ready = 1'($urandom);
      @(negedge clk);
      freeze = m_wait ? !mem_ready : (mem_req && !mem_ready);
      lu = ex_is_load && ex_reg_en && ex_reg_addr != 0 &&
           ((id_rs_used && id_rs_addr == ex_reg_addr) || (id_rt_used && id_rt_addr == ex_reg_addr));
      mdh = (m_cnt > 0) && (id_hilo_read || id_muldiv_start);
      sid = freeze || lu || mdh;
      chk("rnd.sel_rs", int'(bypass_sel_rs), int'(ref_sel(id_rs_addr)));
      chk("rnd.sel_rt", int'(bypass_sel_rt), int'(ref_sel(id_rt_addr)));
      chk("rnd.busy", int'(muldiv_busy), int'(m_cnt > 0));
      chk_ctl("rnd", sid, sid, !freeze && (lu || mdh), freeze, freeze);
      m_wait = m_wait ? !mem_ready : (mem_req && !mem_ready);
      if (id_muldiv_start && !sid) m_cnt = LAT;
      else if (m_cnt > 0) m_cnt--;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
